// File: rtl/fifo_read_ptr_empty_pkg.sv
// Shared async-FIFO pointer helpers, used by the read-side empty logic and
// the write-side full logic.
//   ptr_width(): pointer width for a given RAM address width (address + 1)
//   bin2gray():  binary to reflected Gray, limited to the low w bits
//   gray2bin():  reflected Gray to binary, limited to the low w bits
package fifo_read_ptr_empty_pkg;

  // Widest pointer the helpers handle; callers zero-extend to this width.
  localparam int unsigned MAX_PTR_W = 32;

  // Default RAM address width (FIFO depth 8).
  localparam int unsigned DEFAULT_ADDR_W = 3;

  // One extra pointer bit tracks lap parity, separating full from empty.
  function automatic int unsigned ptr_width(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

  // Bits at or above w are ignored on input and zero on output.
  function automatic logic [MAX_PTR_W-1:0] mask_width(input logic [MAX_PTR_W-1:0] v,
                                                      input int unsigned         w);
    logic [MAX_PTR_W-1:0] m;
    m = '0;
    for (int i = 0; i < int'(MAX_PTR_W); i++) begin
      if (i < int'(w)) m[i] = v[i];
    end
    return m;
  endfunction

  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b,
                                                    input int unsigned         w);
    logic [MAX_PTR_W-1:0] bm;
    bm = mask_width(b, w);
    return bm ^ (bm >> 1);
  endfunction

  // b[i] is the XOR of all Gray bits from i up to the MSB.
  function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g,
                                                    input int unsigned         w);
    logic [MAX_PTR_W-1:0] gm;
    logic [MAX_PTR_W-1:0] b;
    gm = mask_width(g, w);
    b  = '0;
    for (int i = 0; i < int'(MAX_PTR_W); i++) begin
      b[i] = ^(gm >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_read_ptr_empty.sv
// Read-side pointer and empty/status generator for the async FIFO, clocked
// entirely in the read domain.
//   read_clk, read_rst : clock and asynchronous active-high reset
//   read_en            : pop request from the consumer
//   sync_write_ptr     : Gray write pointer, already synchronized into read_clk
//   read_addr          : binary RAM read address (low bits of binary pointer)
//   read_ptr           : registered Gray read pointer for the write domain
//   read_valid         : high the cycle after an accepted pop (RAM data valid)
//   empty              : registered empty flag
//   almost_empty       : registered, fill_level <= AE_THRESH
//   fill_level         : registered count of words available
//   underflow          : sticky, set by a pop attempt while empty
module fifo_read_ptr_empty
  import fifo_read_ptr_empty_pkg::*;
#(
  parameter int unsigned address   = DEFAULT_ADDR_W,
  parameter int unsigned AE_THRESH = 1
) (
  input  logic               read_clk,
  input  logic               read_rst,
  input  logic               read_en,
  input  logic [address:0]   sync_write_ptr,
  output logic [address-1:0] read_addr,
  output logic [address:0]   read_ptr,
  output logic               read_valid,
  output logic               empty,
  output logic               almost_empty,
  output logic [address:0]   fill_level,
  output logic               underflow
);

  localparam int unsigned PTR_W = ptr_width(address);

  logic [PTR_W-1:0] rbin_q,  rbin_d;
  logic [PTR_W-1:0] rgray_q, rgray_d;
  logic [PTR_W-1:0] fill_q,  fill_d;
  logic             empty_q, empty_d;
  logic             ae_q,    ae_d;
  logic             valid_q, valid_d;
  logic             uf_q,    uf_d;

  logic             pop_c;
  logic [PTR_W-1:0] wbin_c;

  // Pops are gated by the registered empty flag only.
  assign pop_c  = read_en & ~empty_q;
  assign wbin_c = PTR_W'(gray2bin(MAX_PTR_W'(sync_write_ptr), PTR_W));

  // Next-state: pointers, occupancy and flags all derive from rbin_d so they
  // stay mutually consistent (empty exactly when fill is zero).
  always_comb begin
    rbin_d  = rbin_q;
    rgray_d = rgray_q;
    fill_d  = fill_q;
    empty_d = empty_q;
    ae_d    = ae_q;
    valid_d = 1'b0;
    uf_d    = uf_q;

    rbin_d  = rbin_q + PTR_W'(pop_c);
    rgray_d = PTR_W'(bin2gray(MAX_PTR_W'(rbin_d), PTR_W));
    // Out-of-range write pointers are reported modulo, not clamped.
    fill_d  = wbin_c - rbin_d;
    empty_d = (rgray_d == sync_write_ptr);
    ae_d    = (MAX_PTR_W'(fill_d) <= AE_THRESH);
    valid_d = pop_c;
    uf_d    = uf_q | (read_en & empty_q);
  end

  // State registers.
  always_ff @(posedge read_clk or posedge read_rst) begin
    if (read_rst) begin
      rbin_q  <= '0;
      rgray_q <= '0;
      fill_q  <= '0;
      empty_q <= 1'b1;
      ae_q    <= 1'b1;
      valid_q <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      rbin_q  <= rbin_d;
      rgray_q <= rgray_d;
      fill_q  <= fill_d;
      empty_q <= empty_d;
      ae_q    <= ae_d;
      valid_q <= valid_d;
      uf_q    <= uf_d;
    end
  end

  assign read_addr    = rbin_q[address-1:0];
  assign read_ptr     = rgray_q;
  assign read_valid   = valid_q;
  assign empty        = empty_q;
  assign almost_empty = ae_q;
  assign fill_level   = fill_q;
  assign underflow    = uf_q;

endmodule

// File: tb/tb_fifo_read_ptr_empty.sv
// Bench for fifo_read_ptr_empty: hand-derived vector table plus a small
// behavioural model feeding a scoreboard queue.
module tb_fifo_read_ptr_empty;

  localparam int unsigned AW = 3;
  localparam int unsigned PW = AW + 1;
  localparam int unsigned AE = 1;

  logic          read_clk = 1'b0;
  logic          read_rst;
  logic          read_en;
  logic [PW-1:0] sync_write_ptr;
  logic [AW-1:0] read_addr;
  logic [PW-1:0] read_ptr;
  logic          read_valid;
  logic          empty;
  logic          almost_empty;
  logic [PW-1:0] fill_level;
  logic          underflow;

  fifo_read_ptr_empty #(.address(AW), .AE_THRESH(AE)) dut (
    .read_clk       (read_clk),
    .read_rst       (read_rst),
    .read_en        (read_en),
    .sync_write_ptr (sync_write_ptr),
    .read_addr      (read_addr),
    .read_ptr       (read_ptr),
    .read_valid     (read_valid),
    .empty          (empty),
    .almost_empty   (almost_empty),
    .fill_level     (fill_level),
    .underflow      (underflow)
  );

  always #5 read_clk = ~read_clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [PW-1:0] ptr;
    logic          valid;
    logic          empty;
    logic          ae;
    logic [PW-1:0] fill;
    logic          uf;
  } exp_t;

  typedef struct {
    logic          rd;
    logic [PW-1:0] wgray;
    exp_t          e;
  } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Model state
  logic [PW-1:0] m_rbin;
  logic          m_empty;
  logic          m_uf;

  function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic vec_t mk(input logic rd, input logic [PW-1:0] wg,
                              input logic [AW-1:0] addr, input logic [PW-1:0] ptr,
                              input logic valid, input logic emp, input logic ae,
                              input logic [PW-1:0] fill, input logic uf);
    vec_t v;
    v.rd      = rd;
    v.wgray   = wg;
    v.e.addr  = addr;
    v.e.ptr   = ptr;
    v.e.valid = valid;
    v.e.empty = emp;
    v.e.ae    = ae;
    v.e.fill  = fill;
    v.e.uf    = uf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty when output was due", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".read_addr"},    32'(read_addr),    32'(e.addr));
      chk({tag, ".read_ptr"},     32'(read_ptr),     32'(e.ptr));
      chk({tag, ".read_valid"},   32'(read_valid),   32'(e.valid));
      chk({tag, ".empty"},        32'(empty),        32'(e.empty));
      chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(e.ae));
      chk({tag, ".fill_level"},   32'(fill_level),   32'(e.fill));
      chk({tag, ".underflow"},    32'(underflow),    32'(e.uf));
    end
  endtask

  // Drive inputs just after an edge, push expectation, compare after next edge.
  task automatic drive(input string tag, input logic rd, input logic [PW-1:0] wg,
                       input exp_t e);
    read_en        = rd;
    sync_write_ptr = wg;
    sb_q.push_back(e);
    @(posedge read_clk);
    #1;
    compare_out(tag);
  endtask

  task automatic model_reset();
    m_rbin  = '0;
    m_empty = 1'b1;
    m_uf    = 1'b0;
  endtask

  task automatic step(input string tag, input logic rd, input logic [PW-1:0] wbin);
    exp_t          e;
    logic          pop;
    logic [PW-1:0] nb;
    logic [PW-1:0] fill;
    pop  = rd & ~m_empty;
    nb   = m_rbin + PW'(pop);
    fill = wbin - nb;
    e.addr  = nb[AW-1:0];
    e.ptr   = to_gray(nb);
    e.valid = pop;
    e.empty = (fill == '0);
    e.ae    = (int'(fill) <= int'(AE));
    e.fill  = fill;
    e.uf    = m_uf | (rd & m_empty);
    m_rbin  = nb;
    m_empty = e.empty;
    m_uf    = e.uf;
    drive(tag, rd, to_gray(wbin), e);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".read_addr"},    32'(read_addr),    32'(0));
    chk({tag, ".read_ptr"},     32'(read_ptr),     32'(0));
    chk({tag, ".read_valid"},   32'(read_valid),   32'(0));
    chk({tag, ".empty"},        32'(empty),        32'(1));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(1));
    chk({tag, ".fill_level"},   32'(fill_level),   32'(0));
    chk({tag, ".underflow"},    32'(underflow),    32'(0));
  endtask

  // Assert reset between edges, check immediately, release after an edge.
  task automatic reset_and_check(input string tag);
    read_rst = 1'b1;
    #1;
    check_reset(tag);
    read_en = 1'b0;
    @(posedge read_clk);
    #1;
    read_rst = 1'b0;
    model_reset();
    sb_q.delete();
  endtask

  vec_t          tbl[6];
  logic [PW-1:0] wb;
  logic [PW-1:0] prev_ptr;

  initial begin
    // Drain of three words (gray 0010), then an underflow attempt.
    tbl[0] = mk(1'b0, 4'b0010, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0);
    tbl[1] = mk(1'b1, 4'b0010, 3'd1, 4'b0001, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0);
    tbl[2] = mk(1'b1, 4'b0010, 3'd2, 4'b0011, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0);
    tbl[3] = mk(1'b1, 4'b0010, 3'd3, 4'b0010, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0);
    tbl[4] = mk(1'b1, 4'b0010, 3'd3, 4'b0010, 1'b0, 1'b1, 1'b1, 4'd0, 1'b1);
    tbl[5] = mk(1'b0, 4'b0010, 3'd3, 4'b0010, 1'b0, 1'b1, 1'b1, 4'd0, 1'b1);

    read_rst       = 1'b0;
    read_en        = 1'b0;
    sync_write_ptr = '0;
    model_reset();

    // 1: asynchronous reset before the first clock edge
    #2;
    reset_and_check("t1_reset");

    // 2: table-driven drain and underflow
    foreach (tbl[i]) drive($sformatf("t2_row%0d", i), tbl[i].rd, tbl[i].wgray, tbl[i].e);

    // 3: full depth from reset
    reset_and_check("t3_reset");
    step("t3_load", 1'b0, 4'd8);
    for (int i = 0; i < 8; i++) step($sformatf("t3_pop%0d", i), 1'b1, 4'd8);

    // 4: wrap-around with the write pointer running ahead
    wb = 4'd12;
    step("t4_load", 1'b0, wb);
    for (int i = 0; i < 18; i++) begin
      wb       = wb + 4'd1;
      prev_ptr = read_ptr;
      step($sformatf("t4_pop%0d", i), 1'b1, wb);
      chk($sformatf("t4_gray_onebit%0d", i), 32'($countones(prev_ptr ^ read_ptr)), 32'(1));
    end

    // 5: last word popped as the write pointer advances
    reset_and_check("t5_reset");
    step("t5_load", 1'b0, 4'd3);
    step("t5_pop0", 1'b1, 4'd3);
    step("t5_pop1", 1'b1, 4'd3);
    step("t5_last", 1'b1, 4'd3);
    step("t5_refill", 1'b0, 4'd4);

    // 6: reset during active pops, then resume
    reset_and_check("t6_pre");
    step("t6_load", 1'b0, 4'd8);
    for (int i = 0; i < 3; i++) step($sformatf("t6_pop%0d", i), 1'b1, 4'd8);
    read_en = 1'b1;
    reset_and_check("t6_midreset");
    step("t6_resume_load", 1'b0, 4'd2);
    step("t6_resume_pop", 1'b1, 4'd2);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_read_ptr_empty.md
Name: fifo_read_ptr_empty

Overview:
- Read-side pointer and empty-flag generator for the async FIFO, clocked in the read domain.
- Consumes the Gray-coded write pointer that has already been synchronized into read_clk.
- Produces the binary RAM read address and the Gray read pointer that is synchronized back into the write domain.
- Generates registered empty, almost-empty, fill-level and underflow status.

Parameters:
- address, 3: RAM address width; FIFO depth is 2^address; pointers are address+1 bits.
- AE_THRESH, 1: almost_empty asserts when fill_level <= AE_THRESH; legal range 0..2^address.

Ports:
- read_clk  in  1  read-domain clock.
- read_rst  in  1  asynchronous active-high reset.
- read_en  in  1  pop request from the consumer.
- sync_write_ptr  in  address+1  Gray write pointer, already synchronized into read_clk.
- read_addr  out  address  binary RAM read address (low bits of the binary read pointer).
- read_ptr  out  address+1  registered Gray read pointer, sent to the write domain.
- read_valid  out  1  high for the cycle after an accepted pop; RAM data is valid then.
- empty  out  1  registered FIFO-empty flag.
- almost_empty  out  1  registered; high when fill_level <= AE_THRESH.
- fill_level  out  address+1  registered count of words available, range 0..2^address.
- underflow  out  1  sticky; set by a pop attempt while empty.

Behaviour:
- Reset: read_clk and read_rst form one clock domain; reset is asynchronous and active-high.
  - On read_rst, immediately and without a clock edge: binary pointer=0, read_ptr=0, read_addr=0, empty=1, almost_empty=1, fill_level=0, read_valid=0, underflow=0.
- Accept rule: pop = read_en & ~empty. empty is the registered flag.
- Pointer update:
  - rbin_next = rbin + pop, computed modulo 2^(address+1).
  - rgray_next = (rbin_next >> 1) ^ rbin_next.
  - Both rbin and rgray are registered every cycle.
  - read_addr = rbin[address-1:0].
  - read_ptr = rgray. It is a plain register output with no combinational path, so it is safe to synchronize.
- Empty:
  - empty <= (rgray_next == sync_write_ptr), re-evaluated every cycle whether or not a pop occurs.
  - A pop of the last word sets empty at that same edge.
  - A write-pointer advance clears empty one read_clk after sync_write_ptr changes.
- Fill level:
  - wbin = Gray-to-binary(sync_write_ptr), where b[MSB]=g[MSB] and b[i]=b[i+1]^g[i].
  - fill_level <= (wbin - rbin_next) modulo 2^(address+1).
  - almost_empty <= (that same value <= AE_THRESH).
  - All status flags are mutually consistent in every cycle: empty=1 exactly when fill_level=0.
- read_valid <= pop, giving one-cycle latency that matches the synchronous-read RAM.
- Underflow:
  - If read_en=1 while empty=1, the pointers hold and underflow is set to 1.
  - underflow stays set until read_rst.
  - No other side effects.
- Wrap-around:
  - Pointers wrap from 2^(address+1)-1 to 0.
  - The Gray read pointer changes exactly one bit per accepted pop, including across the wrap.
  - The pointer MSB distinguishes lap parity.
- Conservative behaviour: fill_level and empty are pessimistic by the synchronizer latency. Stale write pointers can only under-report the words available, never over-report them.
- Out-of-range input: a sync_write_ptr that implies more than 2^address words is a write-side fault. It is not clamped; the modulo result is reported as-is.

Decomposition:
- Shared fifo package:
  - bin2gray and gray2bin functions, parameterized by pointer width.
  - Pointer-width constant derived from address (address+1).
  - These same definitions are used by the write-side full logic.
- No sub-module is required. The gray2bin decode is a package function, and the counter and flags live in this block.

Test Plan:
1. Reset value check, address=3:
   - Assert read_rst mid-clock, with no clock edge.
   - Required: empty=1, almost_empty=1, read_ptr=0000, read_addr=0, fill_level=0, read_valid=0, underflow=0, all immediately.
2. Drain and underflow:
   - Hold sync_write_ptr=0010 (gray 3) and read_en=1 for 4 cycles.
   - Required: read_addr 0→1→2→3; read_ptr 0000→0001→0011→0010.
   - empty=1 at the 3rd accepted edge; read_valid high for 3 cycles.
   - The 4th request sets underflow=1 and the pointers hold.
3. Full depth:
   - From reset, set sync_write_ptr=1100 (gray 8).
   - Required: next cycle fill_level=8, empty=0, almost_empty=0.
   - After 7 pops: fill_level=1, almost_empty=1, empty=0. After the 8th pop: empty=1.
4. Wrap:
   - Step sync_write_ptr ahead and pop 18 words.
   - Required: read_ptr goes 1000 (gray 15) → 0000 with a single-bit change; read_addr 7→0.
   - fill_level stays correct across the wrap; no spurious empty.
5. Simultaneous events:
   - With one word left (rbin=2, sync_write_ptr=0010), pop while sync_write_ptr changes to 0110 (gray 4) at the same edge.
   - Required: empty=1 for one cycle, then empty=0 and fill_level=1.
6. Reset mid-stream:
   - Assert read_rst with fill_level=5 during active pops.
   - Required: all outputs return to reset values asynchronously, and pops resume from read_addr 0 after release.
